// File: rtl/lcd_char_sender.sv
// lcd_char_sender: buffers CPU output bytes and plays each one to the text LCD
// as a single addInput high/low pulse pair while tracking the display column.
// Ports:
//   clk_50    - system clock, rising edge
//   reset     - asynchronous active-high reset
//   out_valid - CPU byte valid;  out_data - CPU byte
//   out_ready - FIFO not full; a byte transfers on out_valid && out_ready
//   addInput  - character strobe, level protocol (latched on rising level)
//   charCode  - 7-bit code, stable through the high phase and following gap
//   lcd_clear - display clear request (constant 0 unless auto-clear is built in)
//   column    - characters sent since reset/clear, modulo SYMBOLS
//   busy      - FIFO non-empty or a pulse/clear sequence in progress
// Build option: define LCD_CHAR_SENDER_AUTOCLEAR_EN to clear the display before
// the first character of a new line and to treat byte 8'h0C as a clear command.
module lcd_char_sender #(
  parameter int DEPTH       = 8,
  parameter int HOLD_CYCLES = 2,
  parameter int GAP_CYCLES  = 2,
  parameter int SYMBOLS     = 16
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic       out_valid,
  input  logic [7:0] out_data,
  output logic       out_ready,
  output logic       addInput,
  output logic [6:0] charCode,
  output logic       lcd_clear,
  output logic [3:0] column,
  output logic       busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int MX = HOLD_CYCLES > GAP_CYCLES ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(MX + 1);
  typedef enum logic [2:0] {
    IDLE, HIGH, GAP
`ifdef LCD_CHAR_SENDER_AUTOCLEAR_EN
    , CLR_HI, CLR_GAP
`endif
  } state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0]    code_q, code_d;
  logic [3:0]    col_q, col_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] wr_q, rd_q;
  logic [7:0]    mem [DEPTH];
  logic          ready_q, nonempty_q, push, pop;
  logic [7:0]    head;
  logic [3:0]    col_next;
`ifdef LCD_CHAR_SENDER_AUTOCLEAR_EN
  logic          full_line_q, full_line_d;
`endif
  assign push     = out_valid && ready_q;
  assign head     = mem[rd_q];
  assign col_next = (col_q == 4'(SYMBOLS - 1)) ? 4'd0 : col_q + 4'd1;
  assign count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
  // The FSM only sees entries a cycle after they land, giving the two-cycle
  // accept-to-strobe latency; it never re-enters IDLE within two cycles of a
  // pop, so the lagging flag cannot cause a read from an empty FIFO.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    col_d   = col_q;
    pop     = 1'b0;
`ifdef LCD_CHAR_SENDER_AUTOCLEAR_EN
    full_line_d = full_line_q;
`endif
    case (state_q)
      IDLE: if (nonempty_q) begin
`ifdef LCD_CHAR_SENDER_AUTOCLEAR_EN
        if (full_line_q) begin
          state_d = CLR_HI;
          cnt_d   = CW'(HOLD_CYCLES - 1);
        end else if (head == 8'h0C) begin
          pop     = 1'b1;
          state_d = CLR_HI;
          cnt_d   = CW'(HOLD_CYCLES - 1);
          col_d   = 4'd0;
        end else
`endif
        begin
          pop     = 1'b1;
          code_d  = head[7] ? 7'h3F : head[6:0];
          cnt_d   = CW'(HOLD_CYCLES - 1);
          state_d = HIGH;
        end
      end
      HIGH: if (cnt_q == '0) begin
        cnt_d   = CW'(GAP_CYCLES - 1);
        col_d   = col_next;
        state_d = GAP;
`ifdef LCD_CHAR_SENDER_AUTOCLEAR_EN
        full_line_d = full_line_q || (col_next == 4'd0);
`endif
      end else cnt_d = cnt_q - CW'(1);
      GAP: if (cnt_q == '0) state_d = IDLE;
        else cnt_d = cnt_q - CW'(1);
`ifdef LCD_CHAR_SENDER_AUTOCLEAR_EN
      CLR_HI: if (cnt_q == '0) begin
        cnt_d       = CW'(GAP_CYCLES - 1);
        full_line_d = 1'b0;
        state_d     = CLR_GAP;
      end else cnt_d = cnt_q - CW'(1);
      CLR_GAP: if (cnt_q == '0) state_d = IDLE;
        else cnt_d = cnt_q - CW'(1);
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      code_q     <= '0;
      col_q      <= '0;
      count_q    <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      ready_q    <= 1'b1;
      nonempty_q <= 1'b0;
`ifdef LCD_CHAR_SENDER_AUTOCLEAR_EN
      full_line_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      code_q     <= code_d;
      col_q      <= col_d;
      count_q    <= count_d;
      wr_q       <= push ? wr_q + AW'(1) : wr_q;
      rd_q       <= pop ? rd_q + AW'(1) : rd_q;
      ready_q    <= count_d != (AW+1)'(DEPTH);
      nonempty_q <= count_q != '0;
`ifdef LCD_CHAR_SENDER_AUTOCLEAR_EN
      full_line_q <= full_line_d;
`endif
    end
  end
  always_ff @(posedge clk_50) begin
    if (push) mem[wr_q] <= out_data;
  end
  assign out_ready = ready_q;
  assign addInput  = state_q == HIGH;
  assign charCode  = code_q;
  assign column    = col_q;
  assign busy      = (count_q != '0) || (state_q != IDLE);
`ifdef LCD_CHAR_SENDER_AUTOCLEAR_EN
  assign lcd_clear = state_q == CLR_HI;
`else
  assign lcd_clear = 1'b0;
`endif
endmodule
